wb_trap_ctrl: RTL
=================

// Module: wb_trap_ctrl
// PURPOSE
//  Sits after the WB stage. Sequences synchronous traps and MRET.
//  Arbitrates the single CSR-file write port between normal CSR writes and the trap sequence.
//  Trap sequence writes mepc, mcause and mtval, then flushes the pipe and redirects fetch.
//  Backpressures the MEM->WB handshake while a trap is in progress.
// PARAMETERS
//  XLEN      32  data/CSR width
//  PC_WIDTH  32  PC width; must be <= XLEN
// PORTS
//  clk               in   1         single clock; all state on posedge
//  rst_n             in   1         asynchronous, active-low reset
//  wb_valid_i        in   1         WB holds a valid retiring instruction this cycle
//  wb_pc_i           in   PC_WIDTH  PC of WB instruction
//  wb_alu_res_i      in   XLEN      ld/st address or branch target (tval source)
//  wb_excp_i         in   9         exception flags, bit order fixed by package EXCP_* indices
//  wb_mret_i         in   1         WB instruction is MRET
//  wb_csr_wen_i      in   1         normal CSR write request
//  wb_csr_idx_i      in   12        normal CSR write address
//  wb_csr_wdata_i    in   XLEN      normal CSR write data
//  mtvec_i           in   XLEN      current mtvec from CSR file
//  mepc_i            in   XLEN      current mepc from CSR file
//  wb_ready_o        out  1         WB may accept a new instruction
//  csr_wen_o         out  1         CSR-file write enable
//  csr_widx_o        out  12        CSR-file write address
//  csr_wdata_o       out  XLEN      CSR-file write data
//  flush_o           out  1         kill all younger instructions IF..MEM
//  redirect_valid_o  out  1         one-cycle fetch redirect
//  redirect_pc_o     out  PC_WIDTH  redirect target
//  trap_commit_o     out  1         pulse; CSR file updates mstatus (MPIE<=MIE, MIE<=0)
//  mret_commit_o     out  1         pulse; CSR file updates mstatus (MIE<=MPIE, MPIE<=1)
// BEHAVIOUR
//  Reset: state=IDLE, cause/tval/epc regs=0. All outputs 0 except wb_ready_o=1. Takes effect immediately (async).
//  States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, REDIR.
//  IDLE:
//   - wb_ready_o=1.
//   - If wb_valid_i & no excp & no mret: csr_* = wb_csr_* (combinational pass-through, same cycle).
//   - If wb_valid_i & |wb_excp_i: latch epc=wb_pc_i, cause and tval; go W_MEPC.
//     That instruction's CSR write is suppressed.
//   - Else if wb_valid_i & wb_mret_i: go REDIR with target mepc_i; its CSR write is suppressed.
//  Cause priority, high->low (code): if_bus_err(1), pc_misalign(0), ilegl_instr(2), ecall(11),
//   ebreak(3), ld_misalign(4), st_misalign(6), ld_bus_err(5), st_bus_err(7).
//  tval by cause:
//   - pc_misalign, ld/st misalign, ld/st bus_err: wb_alu_res_i.
//   - if_bus_err, ebreak: wb_pc_i, zero-extended.
//   - ilegl_instr, ecall: 0.
//  W_MEPC:   csr write 0x341 <= {epc[..:1],1'b0}.
//  W_MCAUSE: csr write 0x342 <= cause (bit XLEN-1 = 0).
//  W_MTVAL:  csr write 0x343 <= tval.
//  REDIR:
//   - redirect_valid_o=1, then back to IDLE.
//   - Trap target = {mtvec_i[..:2],2'b00}, sampled in REDIR; trap_commit_o=1.
//   - MRET target = latched mepc_i; mret_commit_o=1.
//  Non-IDLE states: flush_o=1, wb_ready_o=0, wb_valid_i ignored (upstream holds).
//  Latency: exception sampled at cycle T -> redirect at T+4. MRET at T -> redirect at T+1.
//  Simultaneous events: exception beats MRET; exception/MRET beats same-instr CSR write; multiple flags use priority above.
//  Reset mid-sequence: abort to IDLE; no partial redirect/commit pulse afterwards.
//  Outputs are decoded from state and regs only (except IDLE CSR pass-through), so no comb loop to wb_valid_i.
// STRUCTURE
//  Package wb_trap_pkg: EXCP_* bit indices; CAUSE_* codes; CSR_MEPC/MCAUSE/MTVAL addresses; state enum.
//  Sub-module wb_excp_prio: combinational; wb_excp_i -> {any, cause[4:0], tval_sel}.
//  Top: FSM, epc/cause/tval regs, CSR-port mux.
// TESTING
//  1. IDLE, valid csr_wen idx=0x300 data=0x8 -> same-cycle csr_wen_o=1 idx 0x300 data 0x8; no flush.
//  2. ld_misalign, pc=0x80000010, alu_res=0x1003, mtvec=0x80000101:
//     -> writes 0x341=0x80000010, 0x342=4, 0x343=0x1003 on T+1..T+3;
//     -> redirect 0x80000100 + trap_commit at T+4; flush/ready=0 T+1..T+4.
//  3. ilegl_instr + ecall + csr_wen together -> cause 2, tval 0, no normal CSR write.
//  4. MRET, mepc_i=0x80000200 -> T+1 redirect 0x80000200, mret_commit=1, no CSR write.
//  5. rst_n low during W_MCAUSE -> outputs to reset values at once; no later redirect.
//  6. Back-to-back: ecall then valid add held by upstream -> add accepted only after REDIR (wb_ready_o=1 in IDLE).

Source files
------------

// File: rtl/wb_trap_ctrl_pkg.sv
// Shared definitions for the WB trap controller: exception bit indices,
// cause codes, CSR addresses, FSM states and the priority-decoder payload.
package wb_trap_pkg;

    localparam int unsigned EXCP_W  = 9;
    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned CSR_AW  = 12;

    localparam int unsigned EXCP_PC_MISALIGN  = 0;
    localparam int unsigned EXCP_IF_BUS_ERR   = 1;
    localparam int unsigned EXCP_ILEGL_INSTR  = 2;
    localparam int unsigned EXCP_EBREAK       = 3;
    localparam int unsigned EXCP_LD_MISALIGN  = 4;
    localparam int unsigned EXCP_LD_BUS_ERR   = 5;
    localparam int unsigned EXCP_ST_MISALIGN  = 6;
    localparam int unsigned EXCP_ST_BUS_ERR   = 7;
    localparam int unsigned EXCP_ECALL        = 8;

    localparam logic [CAUSE_W-1:0] CAUSE_PC_MISALIGN = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_IF_BUS_ERR  = 5'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILEGL_INSTR = 5'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK      = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_LD_BUS_ERR  = 5'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = 5'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ST_BUS_ERR  = 5'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL       = 5'd11;

    localparam logic [CSR_AW-1:0] CSR_MEPC   = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL  = 12'h343;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_REDIR
    } state_e;

    typedef enum logic [1:0] {
        TVAL_ZERO,
        TVAL_PC,
        TVAL_ALU
    } tval_sel_e;

    typedef struct packed {
        logic               any;
        logic [CAUSE_W-1:0] cause;
        tval_sel_e          tval_sel;
    } excp_info_t;

endpackage

// File: rtl/wb_trap_ctrl_if.sv
// WB-side handshake, CSR write port and fetch-redirect bundle of the trap controller.
interface wb_trap_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32
);
    logic                wb_valid_i;
    logic [PC_WIDTH-1:0] wb_pc_i;
    logic [XLEN-1:0]     wb_alu_res_i;
    logic [8:0]          wb_excp_i;
    logic                wb_mret_i;
    logic                wb_csr_wen_i;
    logic [11:0]         wb_csr_idx_i;
    logic [XLEN-1:0]     wb_csr_wdata_i;
    logic [XLEN-1:0]     mtvec_i;
    logic [XLEN-1:0]     mepc_i;

    logic                wb_ready_o;
    logic                csr_wen_o;
    logic [11:0]         csr_widx_o;
    logic [XLEN-1:0]     csr_wdata_o;
    logic                flush_o;
    logic                redirect_valid_o;
    logic [PC_WIDTH-1:0] redirect_pc_o;
    logic                trap_commit_o;
    logic                mret_commit_o;

    modport master (
        output wb_valid_i, wb_pc_i, wb_alu_res_i, wb_excp_i, wb_mret_i,
               wb_csr_wen_i, wb_csr_idx_i, wb_csr_wdata_i, mtvec_i, mepc_i,
        input  wb_ready_o, csr_wen_o, csr_widx_o, csr_wdata_o, flush_o,
               redirect_valid_o, redirect_pc_o, trap_commit_o, mret_commit_o
    );

    modport slave (
        input  wb_valid_i, wb_pc_i, wb_alu_res_i, wb_excp_i, wb_mret_i,
               wb_csr_wen_i, wb_csr_idx_i, wb_csr_wdata_i, mtvec_i, mepc_i,
        output wb_ready_o, csr_wen_o, csr_widx_o, csr_wdata_o, flush_o,
               redirect_valid_o, redirect_pc_o, trap_commit_o, mret_commit_o
    );
endinterface

// File: rtl/wb_excp_prio.sv
// Combinational exception priority decoder: flags -> {any, cause, tval source}.
module wb_excp_prio
    import wb_trap_pkg::*;
(
    input  logic [EXCP_W-1:0] excp,
    output excp_info_t        info_c
);

    always_comb begin
        info_c          = '0;
        info_c.tval_sel = TVAL_ZERO;
        info_c.any      = |excp;
        // Highest-priority flag wins; chain order is the architectural priority.
        if (excp[EXCP_IF_BUS_ERR]) begin
            info_c.cause    = CAUSE_IF_BUS_ERR;
            info_c.tval_sel = TVAL_PC;
        end else if (excp[EXCP_PC_MISALIGN]) begin
            info_c.cause    = CAUSE_PC_MISALIGN;
            info_c.tval_sel = TVAL_ALU;
        end else if (excp[EXCP_ILEGL_INSTR]) begin
            info_c.cause    = CAUSE_ILEGL_INSTR;
        end else if (excp[EXCP_ECALL]) begin
            info_c.cause    = CAUSE_ECALL;
        end else if (excp[EXCP_EBREAK]) begin
            info_c.cause    = CAUSE_EBREAK;
            info_c.tval_sel = TVAL_PC;
        end else if (excp[EXCP_LD_MISALIGN]) begin
            info_c.cause    = CAUSE_LD_MISALIGN;
            info_c.tval_sel = TVAL_ALU;
        end else if (excp[EXCP_ST_MISALIGN]) begin
            info_c.cause    = CAUSE_ST_MISALIGN;
            info_c.tval_sel = TVAL_ALU;
        end else if (excp[EXCP_LD_BUS_ERR]) begin
            info_c.cause    = CAUSE_LD_BUS_ERR;
            info_c.tval_sel = TVAL_ALU;
        end else if (excp[EXCP_ST_BUS_ERR]) begin
            info_c.cause    = CAUSE_ST_BUS_ERR;
            info_c.tval_sel = TVAL_ALU;
        end
    end

endmodule

// File: rtl/wb_trap_ctrl.sv
// Post-WB trap/MRET sequencer: owns the CSR write port, writes mepc/mcause/mtval
// on a trap, then flushes the pipe and redirects fetch.
module wb_trap_ctrl
    import wb_trap_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_trap_ctrl_if.slave  bus
);

    state_e              state;
    logic [PC_WIDTH-1:0] epc;
    logic [CAUSE_W-1:0]  cause;
    logic [XLEN-1:0]     tval;
    logic                is_mret;

    excp_info_t          info_c;
    logic [XLEN-1:0]     tval_c;
    logic                unused_bits;

    assign unused_bits = ^{bus.mtvec_i[1:0]};

    wb_excp_prio u_prio (
        .excp   (bus.wb_excp_i),
        .info_c (info_c)
    );

    always_comb begin
        case (info_c.tval_sel)
            TVAL_ALU: tval_c = bus.wb_alu_res_i;
            TVAL_PC:  tval_c = XLEN'(bus.wb_pc_i);
            default:  tval_c = '0;
        endcase
    end

    // Sequencer state and trap context; epc doubles as the latched MRET target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            epc     <= '0;
            cause   <= '0;
            tval    <= '0;
            is_mret <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.wb_valid_i && info_c.any) begin
                        epc     <= bus.wb_pc_i;
                        cause   <= info_c.cause;
                        tval    <= tval_c;
                        is_mret <= 1'b0;
                        state   <= ST_W_MEPC;
                    end else if (bus.wb_valid_i && bus.wb_mret_i) begin
                        epc     <= PC_WIDTH'(bus.mepc_i);
                        is_mret <= 1'b1;
                        state   <= ST_REDIR;
                    end
                end
                ST_W_MEPC:   state <= ST_W_MCAUSE;
                ST_W_MCAUSE: state <= ST_W_MTVAL;
                ST_W_MTVAL:  state <= ST_REDIR;
                ST_REDIR:    state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state/regs; only the IDLE CSR pass-through sees WB inputs.
    always_comb begin
        bus.wb_ready_o       = 1'b0;
        bus.csr_wen_o        = 1'b0;
        bus.csr_widx_o       = '0;
        bus.csr_wdata_o      = '0;
        bus.flush_o          = 1'b1;
        bus.redirect_valid_o = 1'b0;
        bus.redirect_pc_o    = '0;
        bus.trap_commit_o    = 1'b0;
        bus.mret_commit_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.wb_ready_o = 1'b1;
                bus.flush_o    = 1'b0;
                if (bus.wb_valid_i && !info_c.any && !bus.wb_mret_i && bus.wb_csr_wen_i) begin
                    bus.csr_wen_o   = 1'b1;
                    bus.csr_widx_o  = bus.wb_csr_idx_i;
                    bus.csr_wdata_o = bus.wb_csr_wdata_i;
                end
            end
            ST_W_MEPC: begin
                bus.csr_wen_o   = 1'b1;
                bus.csr_widx_o  = CSR_MEPC;
                bus.csr_wdata_o = XLEN'(epc) & ~XLEN'(1);
            end
            ST_W_MCAUSE: begin
                bus.csr_wen_o   = 1'b1;
                bus.csr_widx_o  = CSR_MCAUSE;
                bus.csr_wdata_o = XLEN'(cause);
            end
            ST_W_MTVAL: begin
                bus.csr_wen_o   = 1'b1;
                bus.csr_widx_o  = CSR_MTVAL;
                bus.csr_wdata_o = tval;
            end
            ST_REDIR: begin
                bus.redirect_valid_o = 1'b1;
                bus.trap_commit_o    = !is_mret;
                bus.mret_commit_o    = is_mret;
                bus.redirect_pc_o    = is_mret ? epc
                                     : PC_WIDTH'({bus.mtvec_i[XLEN-1:2], 2'b00});
            end
            default: begin
                bus.flush_o = 1'b1;
            end
        endcase
    end

endmodule
